shift_issue_pipe: RTL

SHIFT_ISSUE_PIPE -- requirements
Module: shift_issue_pipe

---
 rtl/shift_issue_pipe.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/shift_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_left
// Description : Combinational left barrel shifter.
//               Bit positions vacated by the shift take the fill value i_il.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_left #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [SHW-1:0]   i_shift,
    input  logic             i_il,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_stage [0:SHW];

    assign w_stage[0] = i_a;

    // Stage k shifts by 2^k when shift bit k is set.
    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            localparam int c_amt = 1 << k;
            assign w_stage[k+1] = i_shift[k]
                                ? {w_stage[k][WIDTH-1-c_amt:0], {c_amt{i_il}}}
                                : w_stage[k];
        end
    endgenerate

    assign o_y = w_stage[SHW];

endmodule

// ============================================================================
// Module      : shift_issue_pipe
// Description : Two-stage valid/ready shift unit. Stage A captures the
//               request; stage B holds the result. SLL/SLO use the left
//               shifter directly, SRL/SRA wrap it in bit reversals.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_issue_pipe #(
    parameter int data_length = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_op,
    input  logic [$clog2(data_length)-1:0] in_shift,
    input  logic [data_length-1:0]         in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_length-1:0]         out_h,
    output logic                           out_c,
    output logic [15:0]                    op_count
);

    localparam int         c_shw    = $clog2(data_length);
    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;
    localparam logic [1:0] c_op_slo = 2'b11;

    // Stage A: captured request
    logic                   r_a_valid;
    logic [1:0]             r_a_op;
    logic [c_shw-1:0]       r_a_shift;
    logic [data_length-1:0] r_a_b;

    // Stage B: result
    logic                   r_b_valid;
    logic [data_length-1:0] r_b_h;
    logic                   r_b_c;
    logic [15:0]            r_op_count;

    logic                   w_advance;
    logic                   w_accept;
    logic                   w_right;
    logic                   w_il;
    logic [data_length-1:0] w_b_rev;
    logic [data_length-1:0] w_sh_in;
    logic [data_length-1:0] w_sh_out;
    logic [data_length-1:0] w_sh_out_rev;
    logic [data_length-1:0] w_h;
    logic                   w_c;
    logic [c_shw-1:0]       w_idx_left;
    logic [c_shw-1:0]       w_idx_right;

    // A moves to B whenever B is empty or B is being drained this cycle.
    assign w_advance = r_a_valid && (!r_b_valid || out_ready);
    assign in_ready  = !r_a_valid || w_advance;
    assign w_accept  = in_valid && in_ready;

    assign w_right = (r_a_op == c_op_srl) || (r_a_op == c_op_sra);

    // Fill value: ones for SLO, sign bit for SRA, zero otherwise.
    always_comb begin
        w_il = 1'b0;
        case (r_a_op)
            c_op_slo: w_il = 1'b1;
            c_op_sra: w_il = r_a_b[data_length-1];
            default:  w_il = 1'b0;
        endcase
    end

    // Bit reversal of the operand and of the shifter output for right shifts.
    always_comb begin
        w_b_rev      = '0;
        w_sh_out_rev = '0;
        for (int i = 0; i < data_length; i++) begin
            w_b_rev[i]      = r_a_b[data_length-1-i];
            w_sh_out_rev[i] = w_sh_out[data_length-1-i];
        end
    end

    assign w_sh_in = w_right ? w_b_rev : r_a_b;

    shift_left #(
        .WIDTH (data_length),
        .SHW   (c_shw)
    ) u_shift_left (
        .i_a     (w_sh_in),
        .i_shift (r_a_shift),
        .i_il    (w_il),
        .o_y     (w_sh_out)
    );

    assign w_h = w_right ? w_sh_out_rev : w_sh_out;

    // Last bit shifted out: b[W-s] going left, b[s-1] going right.
    assign w_idx_left  = ~r_a_shift + 1'b1;
    assign w_idx_right = r_a_shift - 1'b1;

    // Carry selection; a zero shift moves nothing out.
    always_comb begin
        w_c = 1'b0;
        if (r_a_shift != '0) begin
            if (w_right) begin
                w_c = r_a_b[w_idx_right];
            end else begin
                w_c = r_a_b[w_idx_left];
            end
        end
    end

    // Stage A: load on accept, empty when the entry moves to B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_op    <= c_op_sll;
            r_a_shift <= '0;
            r_a_b     <= '0;
        end else if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_op    <= in_op;
            r_a_shift <= in_shift;
            r_a_b     <= in_b;
        end else if (w_advance) begin
            r_a_valid <= 1'b0;
        end
    end

    // Stage B: load result on advance, empty when drained without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_valid <= 1'b0;
            r_b_h     <= '0;
            r_b_c     <= 1'b0;
        end else if (w_advance) begin
            r_b_valid <= 1'b1;
            r_b_h     <= w_h;
            r_b_c     <= w_c;
        end else if (r_b_valid && out_ready) begin
            r_b_valid <= 1'b0;
        end
    end

    // Count consumed results, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (r_b_valid && out_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign out_valid = r_b_valid;
    assign out_h     = r_b_h;
    assign out_c     = r_b_c;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire
